// File: rtl/diila_ng.sv
// rtl/diila_ng.sv - logic analyzer: circular capture buffer with trigger, Wishbone B3 classic readout
// Optional timestamp memory on region 15 when DIILA_NG_TIMESTAMP_EN is defined.
module diila_ng #(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [31:0]           wb_dat_i,
  input  logic [23:2]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic [31:0]           trig_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sample_en_i,
  output logic                  done_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int NW    = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, post_cnt_q, trig_addr_q, post_r, post_s;
  logic [31:0]     val_r, mask_r, val_s, mask_s;
  logic            edge_r, edge_s, wrapped_q, match_prev_q;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [31:0]           mem_trig [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [31:0]           rd_trig_q;

  logic [3:0]    region, region_q;
  logic [31:0]   reg_rdata, reg_rdata_q, mem_word;
  logic          req, ctrl_wr, arm, abort, match, hit, wr_en;
  logic [AW-1:0] start_addr, rd_idx, post_cnt_inc;
  logic          unused_ok;

  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;
  assign done_o    = (state_q == ST_DONE);
  assign unused_ok = ^{wb_sel_i, wb_adr_i};

  assign region  = wb_adr_i[23:20];
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign ctrl_wr = req & wb_we_i & (region == 4'd0) & (wb_adr_i[4:2] == 3'd0);
  assign abort   = ctrl_wr & wb_dat_i[1];
  assign arm     = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1];

  assign match        = ((trig_i ^ val_s) & mask_s) == 32'd0;
  assign hit          = edge_s ? (match & ~match_prev_q) : match;
  assign post_cnt_inc = post_cnt_q + 1'b1;

  // In TRIGGERED, once the post count is satisfied nothing more is written.
  assign wr_en = sample_en_i & ~arm & ~abort &
                 ((state_q == ST_ARMED) || (state_q == ST_TRIG && post_cnt_q != post_s));

  assign start_addr = wrapped_q ? wr_ptr_q : '0;
  assign rd_idx     = start_addr + wb_adr_i[AW+1:2];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (sample_en_i && hit) state_d = ST_TRIG;
        ST_TRIG: begin
          if (post_cnt_q == post_s)                   state_d = ST_DONE;
          else if (sample_en_i && post_cnt_inc == post_s) state_d = ST_DONE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q     <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      wrapped_q    <= 1'b0;
      match_prev_q <= 1'b0;
      post_r       <= '0;
      val_r        <= '0;
      mask_r       <= '0;
      edge_r       <= 1'b0;
      post_s       <= '0;
      val_s        <= '0;
      mask_s       <= '0;
      edge_s       <= 1'b0;
    end else begin
      if (req && wb_we_i && region == 4'd0) begin
        case (wb_adr_i[4:2])
          3'd0:    edge_r <= wb_dat_i[2];
          3'd1:    post_r <= wb_dat_i[AW-1:0];
          3'd2:    val_r  <= wb_dat_i;
          3'd3:    mask_r <= wb_dat_i;
          default: ;
        endcase
      end
      if (arm) begin
        wr_ptr_q     <= '0;
        post_cnt_q   <= '0;
        wrapped_q    <= 1'b0;
        match_prev_q <= 1'b0;
        post_s       <= post_r;
        val_s        <= val_r;
        mask_s       <= mask_r;
        edge_s       <= wb_dat_i[2];
      end else if (wr_en) begin
        wr_ptr_q     <= wr_ptr_q + 1'b1;
        match_prev_q <= match;
        if (&wr_ptr_q)                  wrapped_q   <= 1'b1;
        if (state_q == ST_ARMED && hit) trig_addr_q <= wr_ptr_q;
        if (state_q == ST_TRIG)         post_cnt_q  <= post_cnt_inc;
      end
    end
  end

  // Block RAM: one write port for capture, one registered read port for the bus.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= data_i;
      mem_trig[wr_ptr_q] <= trig_i;
    end
    rd_data_q <= mem_data[rd_idx];
    rd_trig_q <= mem_trig[rd_idx];
  end

`ifdef DIILA_NG_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] mem_ts [DEPTH];
  logic [31:0] rd_ts_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) ts_q <= '0;
    else if (arm)   ts_q <= '0;
    else            ts_q <= ts_q + 32'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) mem_ts[wr_ptr_q] <= ts_q;
    rd_ts_q <= mem_ts[rd_idx];
  end
`endif

  always_comb begin
    reg_rdata = '0;
    case (wb_adr_i[4:2])
      3'd0: reg_rdata = {29'd0, edge_r, 2'd0};
      3'd1: reg_rdata = 32'(post_r);
      3'd2: reg_rdata = val_r;
      3'd3: reg_rdata = mask_r;
      3'd4: reg_rdata = {28'd0, edge_r, wrapped_q, state_q};
      3'd5: reg_rdata = 32'(trig_addr_q);
      3'd6: reg_rdata = 32'(start_addr);
      3'd7: reg_rdata = wrapped_q ? 32'(DEPTH) : 32'(wr_ptr_q);
      default: reg_rdata = '0;
    endcase
  end

  // Register data is captured with the request; memory data arrives one cycle later, on ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o    <= 1'b0;
      region_q    <= '0;
      reg_rdata_q <= '0;
    end else begin
      wb_ack_o <= req;
      if (req) begin
        region_q    <= region;
        reg_rdata_q <= reg_rdata;
      end
    end
  end

  always_comb begin
    mem_word = '0;
    for (int k = 0; k < NW; k++) begin
      if (region_q == 4'(k + 2)) mem_word = rd_data_q[DATA_WIDTH-1-32*k -: 32];
    end
  end

  always_comb begin
    wb_dat_o = '0;
    case (region_q)
      4'd0:    wb_dat_o = reg_rdata_q;
      4'd1:    wb_dat_o = rd_trig_q;
`ifdef DIILA_NG_TIMESTAMP_EN
      4'd15:   wb_dat_o = rd_ts_q;
`endif
      default: wb_dat_o = mem_word;
    endcase
  end

endmodule

// File: tb/tb_diila_ng.sv
// tb/tb_diila_ng.sv - directed self-checking bench for diila_ng (64-bit data, 16-deep buffer)
module tb_diila_ng;

  localparam int DW  = 64;
  localparam int DL2 = 4;

  localparam logic [23:0] A_CTRL   = 24'h00;
  localparam logic [23:0] A_POST   = 24'h04;
  localparam logic [23:0] A_VAL    = 24'h08;
  localparam logic [23:0] A_MASK   = 24'h0C;
  localparam logic [23:0] A_STATUS = 24'h10;
  localparam logic [23:0] A_TADDR  = 24'h14;
  localparam logic [23:0] A_START  = 24'h18;
  localparam logic [23:0] A_COUNT  = 24'h1C;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   wb_dat_i = '0;
  logic [23:2]   wb_adr_i = '0;
  logic [3:0]    wb_sel_i = 4'hF;
  logic          wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0]   trig_i = '0;
  logic [DW-1:0] data_i = '0;
  logic          sample_en_i = 1'b0;
  logic          done_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;

  diila_ng #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_dat_i(wb_dat_i), .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .trig_i(trig_i), .data_i(data_i), .sample_en_i(sample_en_i), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic [23:0] badr, input logic we, input logic [31:0] wd,
                         output logic [31:0] rdat);
    int n;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = badr[23:2]; wb_dat_i = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) check("ack_timeout", {31'd0, wb_ack_o}, 32'd1);
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [23:0] badr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(badr, 1'b1, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [23:0] badr, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(badr, 1'b0, 32'd0, v);
    check(tag, v, exp);
  endtask

  function automatic logic [23:0] maddr(input int region, input int off);
    return 24'((region << 20) | (off << 2));
  endfunction

  // One capture clock: drive at a falling edge, sampled on the next rising edge.
  task automatic step(input logic [31:0] d, input logic [31:0] t, input logic en);
    data_i = {d + 32'h1000, d};
    trig_i = t;
    sample_en_i = en;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    rst_n = 1'b1;
    rd_chk("rst_status", A_STATUS, 32'd0);
    rd_chk("rst_post", A_POST, 32'd0);
    rd_chk("rst_mask", A_MASK, 32'd0);
    rd_chk("rst_count", A_COUNT, 32'd0);

    // Ramp capture with wrap: trigger on 0x55, three post samples.
    wb_wr(A_POST, 32'd3);
    wb_wr(A_VAL, 32'h55);
    wb_wr(A_MASK, 32'hFFFF_FFFF);
    wb_wr(A_CTRL, 32'h1);
    for (int n = 0; n < 200 && !done_o; n++) step(32'(n), 32'(n), 1'b1);
    sample_en_i = 1'b0;
    check("ramp_done", {31'd0, done_o}, 32'd1);
    rd_chk("ramp_status", A_STATUS, 32'h7);
    rd_chk("ramp_taddr", A_TADDR, 32'd5);
    rd_chk("ramp_count", A_COUNT, 32'd16);
    rd_chk("ramp_start", A_START, 32'd9);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("ramp_lo%0d", i), maddr(3, i), 32'h49 + 32'(i));
    rd_chk("ramp_hi0", maddr(2, 0), 32'h1049);
    rd_chk("ramp_hi15", maddr(2, 15), 32'h1058);
    rd_chk("ramp_trig15", maddr(1, 15), 32'h58);
    rd_chk("ramp_trig0", maddr(1, 0), 32'h49);
    rd_chk("unmapped_r6", maddr(6, 0), 32'd0);
    rd_chk("ts_r15_off", maddr(15, 0), 32'd0);

    // Edge mode: bit0 low, then held high, then toggled.
    wb_wr(A_POST, 32'd15);
    wb_wr(A_VAL, 32'h1);
    wb_wr(A_MASK, 32'h1);
    wb_wr(A_CTRL, 32'h5);
    begin
      logic [8:0] tseq;
      tseq = 9'b1_0111_1100;
      for (int c = 1; c <= 9; c++) step(32'(c), {31'd0, tseq[c-1]}, 1'b1);
    end
    sample_en_i = 1'b0;
    rd_chk("edge_status", A_STATUS, 32'hA);
    rd_chk("edge_taddr", A_TADDR, 32'd2);
    check("edge_notdone", {31'd0, done_o}, 32'd0);

    // Qualifier toggling with POST=2.
    wb_wr(A_POST, 32'd2);
    wb_wr(A_VAL, 32'h7);
    wb_wr(A_MASK, 32'hFFFF_FFFF);
    wb_wr(A_CTRL, 32'h1);
    for (int c = 1; c <= 5; c++) begin
      step(32'h100 + 32'(c), 32'h7, c[0]);
      if (c == 4) check("qual_done_c4", {31'd0, done_o}, 32'd0);
      if (c == 5) check("qual_done_c5", {31'd0, done_o}, 32'd1);
    end
    sample_en_i = 1'b0;
    rd_chk("qual_count", A_COUNT, 32'd3);
    rd_chk("qual_taddr", A_TADDR, 32'd0);
    rd_chk("qual_m0", maddr(3, 0), 32'h101);
    rd_chk("qual_m1", maddr(3, 1), 32'h103);
    rd_chk("qual_m2", maddr(3, 2), 32'h105);

    // POST=0 without wrapping, trigger at index 3.
    wb_wr(A_POST, 32'd0);
    wb_wr(A_VAL, 32'h55);
    wb_wr(A_CTRL, 32'h1);
    for (int c = 1; c <= 4; c++) step(32'h300 + 32'(c), (c == 4) ? 32'h55 : 32'h0, 1'b1);
    check("p0_done_trig", {31'd0, done_o}, 32'd0);
    step(32'h305, 32'h0, 1'b1);
    check("p0_done_next", {31'd0, done_o}, 32'd1);
    sample_en_i = 1'b0;
    rd_chk("p0_count", A_COUNT, 32'd4);
    rd_chk("p0_start", A_START, 32'd0);
    rd_chk("p0_taddr", A_TADDR, 32'd3);
    rd_chk("p0_status", A_STATUS, 32'h3);

    // Abort, arm+abort together, back-to-back reads.
    wb_wr(A_VAL, 32'hDEAD);
    wb_wr(A_CTRL, 32'h1);
    rd_chk("abort_armed", A_STATUS, 32'h1);
    wb_wr(A_CTRL, 32'h2);
    rd_chk("abort_idle", A_STATUS, 32'h0);
    wb_wr(A_CTRL, 32'h1);
    wb_wr(A_CTRL, 32'h3);
    rd_chk("armabort_idle", A_STATUS, 32'h0);

    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_STATUS[23:2];
    @(negedge clk);
    check("b2b_ack1", {31'd0, wb_ack_o}, 32'd1);
    check("b2b_dat1", wb_dat_o, 32'h0);
    wb_adr_i = A_VAL[23:2];
    @(negedge clk);
    check("b2b_gap", {31'd0, wb_ack_o}, 32'd0);
    @(negedge clk);
    check("b2b_ack2", {31'd0, wb_ack_o}, 32'd1);
    check("b2b_dat2", wb_dat_o, 32'hDEAD);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    check("b2b_idle", {31'd0, wb_ack_o}, 32'd0);

    // Reset asserted while TRIGGERED; memory must survive.
    wb_wr(A_POST, 32'd15);
    wb_wr(A_MASK, 32'h0);
    wb_wr(A_CTRL, 32'h1);
    for (int c = 1; c <= 4; c++) step(32'h200 + 32'(c), 32'h0, 1'b1);
    rd_chk("pre_rst_status", A_STATUS, 32'h2);
    sample_en_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_done", {31'd0, done_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_status", A_STATUS, 32'h0);
    rd_chk("post_rst_count", A_COUNT, 32'h0);
    rd_chk("post_rst_post", A_POST, 32'h0);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("keep_m%0d", i), maddr(3, i), 32'h201 + 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
